// File: rtl/ysyx_25040111_lsu_rd_master_pkg.sv
// Shared types for the LSU load path: access sizes, AXI response codes, FSM states.
package ysyx_25040111_lsu_rd_master_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_RSV = 2'd3
  } size_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Requests that must never reach the bus: misaligned half/word or reserved size.
  function automatic logic bad_req(input size_e size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_rd_master_if.sv
// Core load request/response plus AXI4-Lite AR/R channel bundle.
interface ysyx_25040111_lsu_rd_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    input  req_valid, req_addr, req_size, req_signed, rsp_ready,
           arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_err, araddr, arvalid, rready
  );

  modport slave (
    output req_valid, req_addr, req_size, req_signed, rsp_ready,
           arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, araddr, arvalid, rready
  );
endinterface

// File: rtl/ysyx_25040111_load_ext.sv
// Byte/half/word lane select and sign/zero extension of a 32-bit read beat.
module ysyx_25040111_load_ext
  import ysyx_25040111_lsu_rd_master_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (size)
      SIZE_B:  data = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_H:  data = {{16{sgn & sh[15]}}, sh[15:0]};
      SIZE_W:  data = sh;
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/ysyx_25040111_lsu_rd_master.sv
// AXI4-Lite single-outstanding read initiator for core loads, with a bus-time watchdog pulse.
module ysyx_25040111_lsu_rd_master
  import ysyx_25040111_lsu_rd_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ysyx_25040111_lsu_rd_master_if.master   bus,
  output logic                            timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [1:0]         off_q, off_d;
  size_e              size_q, size_d;
  logic               sgn_q, sgn_d;
  logic               req_ready_q, req_ready_d;
  logic               arvalid_q, arvalid_d;
  logic [31:0]        araddr_q, araddr_d;
  logic               rready_q, rready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        ext_data;
  size_e              req_size;

  assign req_size = size_e'(bus.req_size);

  ysyx_25040111_load_ext u_ext (
    .rdata (bus.rdata),
    .off   (off_q),
    .size  (size_q),
    .sgn   (sgn_q),
    .data  (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    req_ready_d = req_ready_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;

    // Watchdog only observes; it never steers the FSM.
    if (state_q == S_AR || state_q == S_R) begin
      if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) timeout_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          off_d       = bus.req_addr[1:0];
          size_d      = req_size;
          sgn_d       = bus.req_signed;
          if (bad_req(req_size, bus.req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
            araddr_d  = {bus.req_addr[31:2], 2'b00};
            cnt_d     = '0;
          end
        end
      end
      S_AR: begin
        if (bus.arready) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (bus.rvalid) begin
          state_d     = S_RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ext_data;
          rsp_err_d   = bus.rresp != RESP_OKAY;
        end
      end
      S_RESP: begin
        // Leaving with req_ready low gives one dead IDLE cycle between loads.
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= SIZE_B;
      sgn_q       <= 1'b0;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.rready    = rready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu_rd_master.sv
// Scoreboarded bench for the LSU read master; bench acts as core and AXI-Lite slave.
module tb_ysyx_25040111_lsu_rd_master;
  import ysyx_25040111_lsu_rd_master_pkg::*;

  logic clk;
  logic rst_n;
  logic timeout;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [32:0] exp_q[$];

  ysyx_25040111_lsu_rd_master_if bus ();

  ysyx_25040111_lsu_rd_master #(.TIMEOUT_CYC(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Core + slave driver. Called and returns at a negedge; reports what it observed.
  task automatic run_load(
    input  logic [31:0] addr, input logic [1:0] size, input logic sgn,
    input  logic [31:0] rd, input logic [1:0] rr,
    input  int ar_dly, input int r_dly, input int rsp_dly,
    output logic [31:0] ar_seen, output logic [31:0] data, output logic err,
    output int lat, output int ar_cyc, output int n_ar, output int n_r,
    output int tmo_n, output int tmo_at, output logic stable, output int hs_cyc);
    int rw, pw;
    logic done;
    ar_seen = '0; data = '0; err = 1'b0; lat = -1; ar_cyc = 0; n_ar = 0; n_r = 0;
    tmo_n = 0; tmo_at = -1; stable = 1'b1; hs_cyc = -1; rw = 0; pw = 0; done = 1'b0;
    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept: req_ready=%0b, required 1", bus.req_ready);
      return;
    end
    hs_cyc = cyc;
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_size = size; bus.req_signed = sgn;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_size = 2'($urandom);
    bus.req_signed = 1'($urandom);
    for (int c = 1; c <= 200 && !done; c++) begin
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rsp_ready = 1'b0;
      bus.rdata = $urandom; bus.rresp = 2'($urandom);
      if (timeout) begin
        tmo_n++;
        if (tmo_at < 0) tmo_at = c;
      end
      if (bus.arvalid) begin
        if (ar_cyc == 0) ar_seen = bus.araddr;
        else if (bus.araddr !== ar_seen) stable = 1'b0;
        if (ar_cyc >= ar_dly) begin bus.arready = 1'b1; n_ar++; end
        ar_cyc++;
      end else if (ar_cyc > 0 && n_ar == 0) stable = 1'b0;
      if (bus.rready) begin
        if (rw >= r_dly) begin
          bus.rvalid = 1'b1; bus.rdata = rd; bus.rresp = rr; n_r++;
        end
        rw++;
      end
      if (bus.rsp_valid) begin
        if (pw == 0) begin data = bus.rsp_data; err = bus.rsp_err; lat = c; end
        else if (bus.rsp_data !== data || bus.rsp_err !== err) stable = 1'b0;
        if (pw >= rsp_dly) begin bus.rsp_ready = 1'b1; done = 1'b1; end
        pw++;
      end
      @(negedge clk);
    end
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rsp_ready = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL rsp_wait: no response within 200 cycles for addr %h", addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
    checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b want 0/0", bus.rsp_data, bus.rsp_err); end
    checks++; if (bus.araddr !== 32'h0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_araddr_tmo: got %h/%b want 0/0", bus.araddr, timeout); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h89ABCDEF});
    run_load(32'h02000048, 2'd2, 1'b0, 32'h89ABCDEF, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if (ara !== 32'h02000048) begin errors++; $display("FAIL word_araddr: got %h want 02000048", ara); end
    checks++; if (d !== exp[31:0]) begin errors++; $display("FAIL word_data: got %h want %h", d, exp[31:0]); end
    checks++; if (e !== exp[32]) begin errors++; $display("FAIL word_err: got %b want %b", e, exp[32]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_latency: got %0d want 3", lat); end
    checks++; if (nar !== 1 || nr !== 1) begin errors++; $display("FAIL word_handshakes: got ar=%0d r=%0d want 1/1", nar, nr); end
    checks++; if (tn !== 0) begin errors++; $display("FAIL word_no_timeout: got %0d pulses want 0", tn); end
  endtask

  task automatic test_byte();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'hFFFFFF80});
    run_load(32'h80000003, 2'd0, 1'b1, 32'h80FF1234, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if (ara !== 32'h80000000) begin errors++; $display("FAIL byte_araddr: got %h want 80000000", ara); end
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL byte_signed: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
    exp_q.push_back({1'b0, 32'h00000080});
    run_load(32'h80000003, 2'd0, 1'b0, 32'h80FF1234, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL byte_unsigned: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
  endtask

  task automatic test_half();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h00007FFF});
    run_load(32'h80000002, 2'd1, 1'b1, 32'h7FFF0000, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if (ara !== 32'h80000000) begin errors++; $display("FAIL half_araddr: got %h want 80000000", ara); end
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL half_off2: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
    exp_q.push_back({1'b0, 32'hFFFF8001});
    run_load(32'h80000000, 2'd1, 1'b1, 32'h12348001, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL half_off0_neg: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
    exp_q.push_back({1'b1, 32'h0});
    run_load(32'h80000001, 2'd1, 1'b1, 32'hFFFFFFFF, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL half_misaligned: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
    checks++; if (arc !== 0 || nr !== 0) begin errors++; $display("FAIL misaligned_no_bus: got ar_cycles=%0d r=%0d want 0/0", arc, nr); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL misaligned_latency: got %0d want 1", lat); end
    exp_q.push_back({1'b1, 32'h0});
    run_load(32'h80000002, 2'd2, 1'b0, 32'hFFFFFFFF, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp || arc !== 0) begin errors++; $display("FAIL word_misaligned: got %b/%h ar=%0d want %b/%h ar=0", e, d, arc, exp[32], exp[31:0]); end
    exp_q.push_back({1'b1, 32'h0});
    run_load(32'h80000000, 2'd3, 1'b0, 32'hFFFFFFFF, RESP_OKAY, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp || arc !== 0) begin errors++; $display("FAIL size_reserved: got %b/%h ar=%0d want %b/%h ar=0", e, d, arc, exp[32], exp[31:0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    run_load(32'h10000004, 2'd2, 1'b0, 32'hCAFEF00D, RESP_OKAY, 5, 4, 3,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", st); end
    checks++; if (nar !== 1 || nr !== 1) begin errors++; $display("FAIL bp_handshakes: got ar=%0d r=%0d want 1/1", nar, nr); end
    checks++; if ({e, d} !== exp || ara !== 32'h10000004) begin errors++; $display("FAIL bp_data: got %b/%h @%h want %b/%h @10000004", e, d, ara, exp[32], exp[31:0]); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL bp_latency: got %0d want 12", lat); end
  endtask

  task automatic test_rresp_err();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b1, 32'h12345678});
    run_load(32'h20000000, 2'd2, 1'b0, 32'h12345678, RESP_SLVERR, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL rresp_slverr: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
    exp_q.push_back({1'b1, 32'h000000AB});
    run_load(32'h20000001, 2'd0, 1'b0, 32'h0000AB00, RESP_DECERR, 0, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL rresp_decerr: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
  endtask

  task automatic test_timeout();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h0BADF00D});
    run_load(32'h30000000, 2'd2, 1'b0, 32'h0BADF00D, RESP_OKAY, 10, 0, 0,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if (tn !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", tn); end
    checks++; if (ta !== 9) begin errors++; $display("FAIL timeout_cycle: got %0d want 9", ta); end
    checks++; if (st !== 1'b1 || arc !== 11) begin errors++; $display("FAIL timeout_arvalid_held: stable=%b ar_cycles=%0d want 1/11", st, arc); end
    checks++; if ({e, d} !== exp) begin errors++; $display("FAIL timeout_data: got %b/%h want %b/%h", e, d, exp[32], exp[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs, hs_prev;
    logic [32:0] exp;
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    hs_prev = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, vals[i]});
      run_load(32'h40000000 + 32'(i * 4), 2'd2, 1'b0, vals[i], RESP_OKAY, 0, 0, 0,
               ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
      exp = exp_q.pop_front();
      checks++; if ({e, d} !== exp) begin errors++; $display("FAIL b2b_data%0d: got %b/%h want %b/%h", i, e, d, exp[32], exp[31:0]); end
      if (i > 0) begin
        checks++; if (hs - hs_prev !== 5) begin errors++; $display("FAIL b2b_period%0d: got %0d cycles want 5", i, hs - hs_prev); end
      end
      hs_prev = hs;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ara, d; logic e, st; int lat, arc, nar, nr, tn, ta, hs;
    logic [32:0] exp;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h50000000; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL rstmid_in_r: rready=%b want 1", bus.rready); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.arvalid, bus.rready, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_outputs: arvalid/rready/rsp_valid/req_ready=%b want 0000",
               {bus.arvalid, bus.rready, bus.rsp_valid, bus.req_ready});
    end
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
    exp_q.push_back({1'b0, 32'hFFFFA5A5});
    run_load(32'h50000002, 2'd1, 1'b1, 32'hA5A51234, RESP_OKAY, 1, 1, 1,
             ara, d, e, lat, arc, nar, nr, tn, ta, st, hs);
    exp = exp_q.pop_front();
    checks++; if ({e, d} !== exp || nar !== 1 || nr !== 1) begin errors++; $display("FAIL rstmid_after: got %b/%h ar=%0d r=%0d want %b/%h 1/1", e, d, nar, nr, exp[32], exp[31:0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0; bus.req_signed = 1'b0;
    bus.rsp_ready = 1'b0; bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_rresp_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
